// File: rtl/gpio_led_pkg.sv
// Shared constants and the per-channel mode decode for the GPIO LED controller.
package gpio_led_pkg;

    localparam int unsigned DEF_CLK_HZ = 25000000;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_PASS  = 2'b10;
    localparam logic [1:0] MODE_BLINK = 2'b11;

    // Value one LED channel should show for its mode, before the global enable.
    function automatic logic chan_drive(input logic [1:0] mode, input logic rasp,
                                        input logic blink);
        logic r;
        r = 1'b0;
        case (mode)
            MODE_OFF:   r = 1'b0;
            MODE_ON:    r = 1'b1;
            MODE_PASS:  r = rasp;
            MODE_BLINK: r = blink;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gpio_led_ctrl_if.sv
// Pi GPIO / board-side signal bundle of the LED controller; slave = controller side.
interface gpio_led_ctrl_if #(
    parameter int unsigned N_CH = 4
);
    logic [2*N_CH-1:0] mode_i;
    logic [N_CH-1:0]   rasp_i;
    logic              btn_i;
    logic              btn_o;
    logic              btn_press_o;
    logic              tick_o;
    logic              blink_o;
    logic              led_en_o;
    logic [N_CH-1:0]   led_o;

    modport slave (
        input  mode_i, rasp_i, btn_i,
        output btn_o, btn_press_o, tick_o, blink_o, led_en_o, led_o
    );

    modport master (
        output mode_i, rasp_i, btn_i,
        input  btn_o, btn_press_o, tick_o, blink_o, led_en_o, led_o
    );
endinterface

// File: rtl/btn_debounce.sv
// Button synchroniser plus debouncer and rising-edge pulse.
// Counter-based debouncing only when GPIO_LED_DEBOUNCE_EN is defined; otherwise plain 2-flop sync.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic stable;

    if (DB_CYCLES == 0) begin : g_cfg_check
        $error("btn_debounce: DB_CYCLES must be at least 1");
    end

`ifdef GPIO_LED_DEBOUNCE_EN
    localparam int unsigned DCW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DCW-1:0] DB_LAST = DCW'(DB_CYCLES - 1);

    logic           stable_q, stable_d;
    logic [DCW-1:0] dbc_q, dbc_d;

    // Any return to the accepted level restarts the stability count.
    always_comb begin
        stable_d = stable_q;
        dbc_d    = '0;
        if (s2_q != stable_q) begin
            if (dbc_q == DB_LAST) begin
                stable_d = ~stable_q;
            end else begin
                dbc_d = dbc_q + DCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= 1'b0;
            dbc_q    <= '0;
        end else begin
            stable_q <= stable_d;
            dbc_q    <= dbc_d;
        end
    end

    assign stable = stable_q;
`else
    assign stable = s2_q;
`endif

    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        prev_d = stable;
        rise_d = stable & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign dout = stable;
    assign rise = rise_q;

endmodule

// File: rtl/gpio_led_ctrl.sv
// N-channel LED controller: blink prescaler, per-channel mode mux, button-toggled global enable.
// Button debouncing is selected with GPIO_LED_DEBOUNCE_EN (see btn_debounce).
module gpio_led_ctrl
    import gpio_led_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned HALF_PERIOD = DEF_CLK_HZ / 2,
    parameter int unsigned DB_CYCLES   = DEF_CLK_HZ / 100
) (
    input  logic           clk,
    input  logic           rst,
    gpio_led_ctrl_if.slave bus
);

    localparam int unsigned MW = 2 * N_CH;
    localparam int unsigned CW = $clog2(HALF_PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);

    logic [MW-1:0]   mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
    logic [N_CH-1:0] rasp_s1_q, rasp_s1_d, rasp_s2_q, rasp_s2_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tick_q, tick_d;
    logic            blink_q, blink_d;
    logic            btn_d1_q, btn_d1_d;
    logic            led_en_q, led_en_d;
    logic [N_CH-1:0] led_q, led_d;
    logic [N_CH-1:0] chan_val;
    logic            cnt_wrap;
    logic            btn_lvl;
    logic            btn_rise;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.btn_i),
        .dout (btn_lvl),
        .rise (btn_rise)
    );

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign chan_val[k] = chan_drive(mode_s2_q[2*k +: 2], rasp_s2_q[k], blink_q);
    end

    // tick is registered from the next count so it is high exactly while cnt == HALF_PERIOD-1.
    always_comb begin
        mode_s1_d = bus.mode_i;
        mode_s2_d = mode_s1_q;
        rasp_s1_d = bus.rasp_i;
        rasp_s2_d = rasp_s1_q;
        cnt_wrap  = (cnt_q == CNT_LAST);
        cnt_d     = cnt_wrap ? '0 : cnt_q + CW'(1);
        tick_d    = (cnt_d == CNT_LAST);
        blink_d   = blink_q ^ cnt_wrap;
        btn_d1_d  = btn_lvl;
        led_en_d  = led_en_q ^ (btn_lvl & ~btn_d1_q);
        led_d     = chan_val & {N_CH{led_en_q}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_s1_q <= '0;
            mode_s2_q <= '0;
            rasp_s1_q <= '0;
            rasp_s2_q <= '0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            blink_q   <= 1'b0;
            btn_d1_q  <= 1'b0;
            led_en_q  <= 1'b1;
            led_q     <= '0;
        end else begin
            mode_s1_q <= mode_s1_d;
            mode_s2_q <= mode_s2_d;
            rasp_s1_q <= rasp_s1_d;
            rasp_s2_q <= rasp_s2_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            blink_q   <= blink_d;
            btn_d1_q  <= btn_d1_d;
            led_en_q  <= led_en_d;
            led_q     <= led_d;
        end
    end

    assign bus.tick_o      = tick_q;
    assign bus.blink_o     = blink_q;
    assign bus.btn_o       = btn_lvl;
    assign bus.btn_press_o = btn_rise;
    assign bus.led_en_o    = led_en_q;
    assign bus.led_o       = led_q;

endmodule

// File: tb/tb_gpio_led_ctrl.sv
// Scoreboard bench for gpio_led_ctrl: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
// Expectations follow GPIO_LED_DEBOUNCE_EN the same way the design does.
module tb_gpio_led_ctrl;

    localparam int unsigned N_CH = 4;
    localparam int unsigned HP   = 4;
    localparam int unsigned DB   = 3;
`ifdef GPIO_LED_DEBOUNCE_EN
    localparam int unsigned DLY  = 2 + DB;
`else
    localparam int unsigned DLY  = 2;
`endif

    localparam int unsigned S_TICK  = 0;
    localparam int unsigned S_BLINK = 1;
    localparam int unsigned S_BTN   = 2;
    localparam int unsigned S_PRESS = 3;
    localparam int unsigned S_EN    = 4;
    localparam int unsigned S_LED   = 5;
    localparam int unsigned S_PCNT  = 6;

    typedef struct {
        int unsigned cyc;
        int unsigned sig;
        logic [7:0]  val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned rbase = 0;
    int unsigned press_cnt = 0;
    int checks = 0;
    int failures = 0;
    exp_t sbq[$];
    logic [7:0] mon_act;

    gpio_led_ctrl_if #(.N_CH(N_CH)) bus_if ();

    gpio_led_ctrl #(
        .N_CH        (N_CH),
        .HALF_PERIOD (HP),
        .DB_CYCLES   (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sig_name(input int unsigned s);
        case (s)
            S_TICK:  return "tick_o";
            S_BLINK: return "blink_o";
            S_BTN:   return "btn_o";
            S_PRESS: return "btn_press_o";
            S_EN:    return "led_en_o";
            S_LED:   return "led_o";
            default: return "press_count";
        endcase
    endfunction

    function automatic logic [7:0] actual(input int unsigned s);
        case (s)
            S_TICK:  return {7'd0, bus_if.tick_o};
            S_BLINK: return {7'd0, bus_if.blink_o};
            S_BTN:   return {7'd0, bus_if.btn_o};
            S_PRESS: return {7'd0, bus_if.btn_press_o};
            S_EN:    return {7'd0, bus_if.led_en_o};
            S_LED:   return {4'd0, bus_if.led_o};
            default: return 8'(press_cnt);
        endcase
    endfunction

    function automatic void push(input int unsigned c, input int unsigned s, input logic [7:0] v);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        sbq.push_back(e);
    endfunction

    // Blink level after edge c: toggles every HP cycles counted from the last reset release.
    function automatic logic blink_at(input int unsigned c);
        return 1'(((c - rbase) / HP) % 2);
    endfunction

    // Enabled LED pattern for mode 11_10_01_00: {blink one cycle late, rasp[2], 1, 0}.
    function automatic logic [7:0] led_on(input int unsigned c, input logic r2);
        return {4'd0, blink_at(c - 1), r2, 1'b1, 1'b0};
    endfunction

    function automatic void push_reset(input int unsigned c);
        push(c, S_TICK, 8'd0);
        push(c, S_BLINK, 8'd0);
        push(c, S_BTN, 8'd0);
        push(c, S_PRESS, 8'd0);
        push(c, S_EN, 8'd1);
        push(c, S_LED, 8'd0);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int unsigned c);
        while (cyc < c) step(1);
    endtask

    // Monitor: compare every expectation due at this cycle; anything overdue is also a failure.
    always @(negedge clk) begin
        if (bus_if.btn_press_o === 1'b1) press_cnt++;
        for (int i = int'(sbq.size()) - 1; i >= 0; i--) begin
            if (sbq[i].cyc <= cyc) begin
                mon_act = actual(sbq[i].sig);
                checks++;
                if (sbq[i].cyc < cyc) begin
                    failures++;
                    $display("FAIL %s stale expectation for cyc=%0d at cyc=%0d", sig_name(sbq[i].sig),
                             sbq[i].cyc, cyc);
                end else if (mon_act !== sbq[i].val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%0h expected=%0h", sig_name(sbq[i].sig), cyc,
                             mon_act, sbq[i].val);
                end
                sbq.delete(i);
            end
        end
    end

    initial begin
        int unsigned p, q, b, e;
        logic [7:0] bpat;

        // Reset held five cycles with random inputs.
        bus_if.mode_i = 8'($urandom);
        bus_if.rasp_i = 4'($urandom);
        bus_if.btn_i  = 1'($urandom);
        step(1);
        for (int k = 0; k <= 4; k++) push_reset(cyc + k);
        repeat (4) begin
            bus_if.mode_i = 8'($urandom);
            bus_if.rasp_i = 4'($urandom);
            bus_if.btn_i  = 1'($urandom);
            step(1);
        end

        // Release with all four modes applied; tick on cycles 4, 8, 12, 16.
        rst           = 1'b0;
        rbase         = cyc;
        bus_if.mode_i = 8'b11_10_01_00;
        bus_if.rasp_i = 4'b0100;
        bus_if.btn_i  = 1'b0;
        for (int unsigned k = 1; k <= 16; k++) begin
            push(rbase + k, S_TICK, {7'd0, (k % HP) == HP - 1});
            push(rbase + k, S_BLINK, {7'd0, blink_at(rbase + k)});
            push(rbase + k, S_LED, (k < 3) ? 8'd0 : led_on(rbase + k, k < 13));
        end
        step_to(rbase + 10);
        bus_if.rasp_i = 4'b0000;
        step_to(rbase + 16);

        // Clean press: enable drops and LEDs go dark.
        p = cyc;
        bus_if.btn_i = 1'b1;
        push(p + DLY - 1, S_BTN, 8'd0);
        push(p + DLY, S_BTN, 8'd1);
        push(p + DLY, S_PRESS, 8'd0);
        push(p + DLY + 1, S_PRESS, 8'd1);
        push(p + DLY + 2, S_PRESS, 8'd0);
        push(p + DLY, S_EN, 8'd1);
        push(p + DLY + 1, S_EN, 8'd0);
        push(p + DLY + 1, S_LED, led_on(p + DLY + 1, 1'b0));
        push(p + DLY + 2, S_LED, 8'd0);
        push(p + DLY + 2, S_PCNT, 8'd1);
        step_to(p + 10);

        // Release: level falls, no pulse.
        q = cyc;
        bus_if.btn_i = 1'b0;
        push(q + DLY - 1, S_BTN, 8'd1);
        push(q + DLY, S_BTN, 8'd0);
        push(q + DLY + 3, S_PCNT, 8'd1);
        push(q + 4, S_LED, 8'd0);
        step_to(q + 10);

`ifdef GPIO_LED_DEBOUNCE_EN
        // Bouncy press 1,0,1,1,0,1,1,1: only the final 3-cycle run is accepted.
        b    = cyc;
        bpat = 8'b1110_1101;
        for (int j = 0; j < 8; j++) begin
            bus_if.btn_i = bpat[j];
            step(1);
        end
        push(b + 6, S_BTN, 8'd0);
        push(b + 9, S_BTN, 8'd0);
        push(b + 10, S_BTN, 8'd1);
        push(b + 10, S_PRESS, 8'd0);
        push(b + 11, S_PRESS, 8'd1);
        push(b + 12, S_PRESS, 8'd0);
        push(b + 10, S_EN, 8'd0);
        push(b + 11, S_EN, 8'd1);
        push(b + 11, S_LED, 8'd0);
        push(b + 12, S_LED, led_on(b + 12, 1'b0));
        push(b + 12, S_PCNT, 8'd2);
        step_to(b + 15);
        q = cyc;
        bus_if.btn_i = 1'b0;
        push(q + 4, S_BTN, 8'd1);
        push(q + 5, S_BTN, 8'd0);
        push(q + 8, S_PCNT, 8'd2);
        step_to(q + 10);
`else
        // One-cycle glitch passes straight through the synchroniser.
        b = cyc;
        bus_if.btn_i = 1'b1;
        step(1);
        bus_if.btn_i = 1'b0;
        push(b + 1, S_BTN, 8'd0);
        push(b + 2, S_BTN, 8'd1);
        push(b + 3, S_BTN, 8'd0);
        push(b + 3, S_PRESS, 8'd1);
        push(b + 4, S_PRESS, 8'd0);
        push(b + 2, S_EN, 8'd0);
        push(b + 3, S_EN, 8'd1);
        push(b + 4, S_LED, led_on(b + 4, 1'b0));
        push(b + 5, S_PCNT, 8'd2);
        step_to(b + 10);
`endif

        // Reset while cnt == 2 (and, when debouncing, with a count of 2 pending).
        e = cyc + 5;
        while (((e - 1 - rbase) % HP) != 2) e++;
        step_to(e - 5);
`ifdef GPIO_LED_DEBOUNCE_EN
        bus_if.btn_i = 1'b1;
`endif
        step_to(e - 1);
        push(e - 1, S_TICK, 8'd0);
        push(e - 1, S_BLINK, {7'd0, blink_at(e - 1)});
        push(e - 1, S_BTN, 8'd0);
        rst = 1'b1;
        step_to(e);
        rst   = 1'b0;
        rbase = cyc;
        push_reset(rbase);
        push(rbase + 1, S_LED, 8'd0);
        push(rbase + 2, S_TICK, 8'd0);
        push(rbase + 2, S_LED, 8'd0);
        push(rbase + 3, S_TICK, 8'd1);
        push(rbase + 3, S_BLINK, 8'd0);
        push(rbase + 3, S_LED, led_on(rbase + 3, 1'b0));
        push(rbase + 4, S_BLINK, 8'd1);
        push(rbase + 7, S_TICK, 8'd1);
`ifdef GPIO_LED_DEBOUNCE_EN
        push(rbase + 4, S_BTN, 8'd0);
        push(rbase + 5, S_BTN, 8'd1);
        push(rbase + 6, S_PRESS, 8'd1);
        push(rbase + 6, S_EN, 8'd0);
        push(rbase + 7, S_LED, 8'd0);
        push(rbase + 7, S_PCNT, 8'd3);
`else
        push(rbase + 7, S_BTN, 8'd0);
        push(rbase + 7, S_EN, 8'd1);
        push(rbase + 7, S_PCNT, 8'd2);
`endif
        step_to(rbase + 12);
        bus_if.btn_i = 1'b0;

        for (int i = 0; i < 40 && sbq.size() != 0; i++) step(1);
        step(2);
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_led_ctrl.md
# gpio_led_ctrl

Parametrised N-channel LED controller for the Trion/Raspberry Pi GPIO bridge. It generates a programmable blink base and a one-cycle tick, and debounces the FPGA push-button into a level and a press pulse. It also drives each LED from a 2-bit mode that the Pi writes over the GPIO bus: off, on, pass-through or blink. It sits between the Pi GPIO pins, the board button/LEDs, and the debug probe bus.

## Interface
Parameters:
- `N_CH`, 4: number of LED channels; mode bus is `2*N_CH` bits wide (default matches the 8-bit Pi GPIO bus).
- `HALF_PERIOD`, 12500000: clk cycles per blink half-period (0.5 s at 25 MHz); legal range ≥ 2.
- `DB_CYCLES`, 250000: consecutive stable cycles required to accept a button change (10 ms at 25 MHz); legal range ≥ 1.

Ports:
- `clk`, in, 1: single system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `mode_i`, in, 2*N_CH: per-channel mode from Pi GPIO, asynchronous; channel k uses bits [2k+1:2k].
- `rasp_i`, in, N_CH: per-channel pass-through source from Pi, asynchronous.
- `btn_i`, in, 1: raw board button, asynchronous, active-high.
- `btn_o`, out, 1: debounced button level (to Pi).
- `btn_press_o`, out, 1: one-cycle pulse on debounced 0→1.
- `tick_o`, out, 1: one-cycle pulse at each blink half-period end.
- `blink_o`, out, 1: square wave with a period of 2*HALF_PERIOD cycles (to Pi).
- `led_en_o`, out, 1: global LED enable; toggled by button press.
- `led_o`, out, N_CH: LED drive.

## Operation
- **Input synchronisers:** all asynchronous inputs (`mode_i`, `rasp_i`, `btn_i`) pass through 2-flop synchronisers before use.
- **Prescaler:** `cnt` counts 0..HALF_PERIOD-1 and wraps to 0.
  - `tick_o` = 1 in the cycle `cnt`==HALF_PERIOD-1.
  - `blink_o` toggles on the clock edge that ends that cycle.
  - Counter width is `$clog2(HALF_PERIOD)`. No off-by-one: the period is exactly 2*HALF_PERIOD cycles.
- **Channel modes:** 00 OFF → 0; 01 ON → 1; 10 PASS → synced `rasp_i[k]`; 11 BLINK → `blink_o`.
- **LED output:** `led_o[k]` = registered (mode result AND `led_en_o`).
- **Debounce:** the debouncer holds a `stable` state and a counter.
  - The counter clears whenever synced input == `stable`.
  - The counter increments while they differ.
  - When the counter reaches DB_CYCLES-1 while still differing, `stable` flips and the counter clears.
  - Any bounce back to the `stable` value restarts the count.
- **Button outputs:** `btn_o` = `stable`. `btn_press_o` pulses in the cycle after `stable` goes 0→1. A release produces no pulse.
- **Global enable:** `led_en_o` toggles on every `btn_press_o`.
- **Reset values:** `cnt`=0, `blink_o`=0, `tick_o`=0, `btn_o`=0, `btn_press_o`=0, `led_en_o`=1, `led_o`=0, all synchroniser flops 0, debounce counter 0.
- **Reset mid-operation:** `rst` asserted at any time returns all state to the reset values on the next edge. Blink phase and any debounce count in progress are discarded.
- **Simultaneous events:** a `tick_o` and a mode change in the same cycle both take effect. The LED takes the new mode using the post-toggle `blink_o`.

## Timing
- **mode_i / rasp_i → led_o:** 3 cycles (2 sync + 1 output register).
- **blink_o → led_o** (BLINK mode): 1 cycle.
- **btn_i → btn_o:** 2 + DB_CYCLES cycles for a clean edge.
- **btn_press_o:** one cycle after `btn_o` rises.
- **led_en_o:** toggles in the same cycle as `btn_press_o`.
- **led_o after press:** reflects the new enable one cycle later.
- **First tick after reset release:** `tick_o` first asserts HALF_PERIOD cycles after the first cycle with `rst`=0.

## Configuration
- Macro: `GPIO_LED_DEBOUNCE_EN`.
- **Defined:** the debouncer is built as described above.
- **Undefined:** `stable` = synced `btn_i` (pure 2-flop sync, no counter, DB_CYCLES ignored). `btn_press_o` and the `led_en_o` toggle still operate on this raw synced edge.

## Structure
- **Package `gpio_led_pkg`:**
  - mode localparams `MODE_OFF`=2'b00, `MODE_ON`=2'b01, `MODE_PASS`=2'b10, `MODE_BLINK`=2'b11.
  - a default-clock constant, 25000000.
- **Sub-module `btn_debounce`:**
  - parameter DB_CYCLES.
  - ports `clk`, `rst`, `din`, `dout`, `rise`.
  - contains the synchroniser and the `GPIO_LED_DEBOUNCE_EN` branch.
- **Top level:** the prescaler, the N_CH mode mux (generate loop) and the enable toggle live in `gpio_led_ctrl`.

## Test plan
Bench parameters: N_CH=4, HALF_PERIOD=4, DB_CYCLES=3.
- **Reset:** hold `rst` 5 cycles with random inputs → all outputs 0 except `led_en_o`=1. After release, `tick_o` first pulses on cycle 4, then every 4 cycles; `blink_o` period is 8.
- **Modes:** `mode_i`=8'b11_10_01_00 with `rasp_i`=4'b0100 → after 3 cycles, `led_o[0]`=0, `led_o[1]`=1, `led_o[2]`=1, and `led_o[3]` tracks `blink_o` delayed by 1 cycle.
- **Clean press:** `btn_i` 0→1 held → `btn_o` rises exactly 5 cycles later, followed by one `btn_press_o` pulse. `led_en_o` goes to 0 and `led_o` goes to 0000 one cycle after that.
- **Bounce:** `btn_i` pattern 1,0,1,1,0,1,1,1 → `btn_o` rises only after the final 3-cycle stable run. Exactly one `btn_press_o` pulse. Release produces no pulse.
- **Reset mid-count:** assert `rst` at `cnt`=2 with a debounce count of 2 pending → both counts cleared. The next tick comes 4 cycles after release, and `btn_o` does not rise early.
- **Macro off:** rebuild without `GPIO_LED_DEBOUNCE_EN`; a 1-cycle `btn_i` glitch → `btn_o` pulses for 1 cycle, 2 cycles later, and `led_en_o` toggles.
